// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from EX and MEM,
// load-use hazard detection (stall plus bubble) and flush squashing.
module id_ex_operand_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         id_valid,
    input  logic [5:0]   id_op,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic [4:0]   id_rd,
    input  logic [4:0]   id_shamt,
    input  logic [5:0]   id_func,
    input  logic [29:0]  id_pc,
    input  logic [W-1:0] id_ra,
    input  logic [W-1:0] id_rb,
    input  logic         id_regwr,
    input  logic         id_regdst,
    input  logic         id_memrd,
    input  logic         id_memwr,
    input  logic [W-1:0] ex_result,
    input  logic         mem_regwr,
    input  logic [4:0]   mem_dst,
    input  logic [W-1:0] mem_data,
    input  logic         flush,
    output logic         stall_if,
    output logic         ex_valid,
    output logic         ex_regwr,
    output logic         ex_memrd,
    output logic         ex_memwr,
    output logic [5:0]   ex_op,
    output logic [5:0]   ex_func,
    output logic [4:0]   ex_shamt,
    output logic [4:0]   ex_dst,
    output logic [29:0]  ex_pc,
    output logic [W-1:0] ex_a,
    output logic [W-1:0] ex_b,
    output logic [15:0]  ex_imm
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    typedef struct packed {
        logic         valid;
        logic         regwr;
        logic         memrd;
        logic         memwr;
        logic [5:0]   op;
        logic [5:0]   func;
        logic [4:0]   shamt;
        logic [4:0]   dst;
        logic [29:0]  pc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [15:0]  imm;
    } ex_reg_t;

    ex_reg_t      ex_q;
    ex_reg_t      ex_d;
    logic         is_jal;
    logic         is_jalr;
    logic         is_lui;
    logic         reads_rt;
    logic         ex_fwd;
    logic         hz;
    logic [4:0]   dst_sel;
    logic [4:0]   id_dst;
    logic [W-1:0] fwd_a;
    logic [W-1:0] fwd_b;

    assign is_jal   = (id_op == OP_JAL);
    assign is_jalr  = (id_op == OP_SPECIAL) && (id_rt == 5'd0) && (id_rd == 5'd31) &&
                      (id_shamt == 5'd0) && (id_func == FN_JALR);
    assign is_lui   = (id_op == OP_LUI);
    assign reads_rt = (id_op == OP_SPECIAL) || id_memwr || (id_op == OP_BEQ) || (id_op == OP_BNE);

    assign dst_sel = (is_jal || is_jalr) ? 5'd31 :
                     is_lui              ? id_rt :
                     id_regdst           ? id_rd : id_rt;
    assign id_dst  = id_regwr ? dst_sel : 5'd0;

    // A load in EX has no data yet; only non-load EX results are forwardable.
    assign ex_fwd = ex_q.valid && ex_q.regwr && !ex_q.memrd;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fwd_a = id_ra;
        if (id_rs == 5'd0)                          fwd_a = '0;
        else if (ex_fwd && (ex_q.dst == id_rs))     fwd_a = ex_result;
        else if (mem_regwr && (mem_dst == id_rs))   fwd_a = mem_data;

        fwd_b = id_rb;
        if (id_rt == 5'd0)                          fwd_b = '0;
        else if (ex_fwd && (ex_q.dst == id_rt))     fwd_b = ex_result;
        else if (mem_regwr && (mem_dst == id_rt))   fwd_b = mem_data;
    end

    assign hz = id_valid && ex_q.valid && ex_q.memrd && (ex_q.dst != 5'd0) &&
                ((ex_q.dst == id_rs) || (reads_rt && (ex_q.dst == id_rt)));

    // Flush wins: the squashed instruction never needs the front end held.
    assign stall_if = hz && !flush;

    always_comb begin
        ex_d = '0;
        if (!flush && !hz) begin
            ex_d.valid = id_valid;
            ex_d.regwr = id_regwr;
            ex_d.memrd = id_memrd;
            ex_d.memwr = id_memwr;
            ex_d.op    = id_op;
            ex_d.func  = id_func;
            ex_d.shamt = id_shamt;
            ex_d.dst   = id_dst;
            ex_d.pc    = id_pc;
            ex_d.a     = fwd_a;
            ex_d.b     = fwd_b;
            ex_d.imm   = {id_rd, id_shamt, id_func};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign ex_valid = ex_q.valid;
    assign ex_regwr = ex_q.regwr;
    assign ex_memrd = ex_q.memrd;
    assign ex_memwr = ex_q.memwr;
    assign ex_op    = ex_q.op;
    assign ex_func  = ex_q.func;
    assign ex_shamt = ex_q.shamt;
    assign ex_dst   = ex_q.dst;
    assign ex_pc    = ex_q.pc;
    assign ex_a     = ex_q.a;
    assign ex_b     = ex_q.b;
    assign ex_imm   = ex_q.imm;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench: an architectural register model drives the surrounding
// pipeline and queues expected EX contents; a monitor pops and compares.
module tb_id_ex_operand_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_regwr, id_regdst, id_memrd, id_memwr;
    logic [5:0] id_op, id_func;
    logic [4:0] id_rs, id_rt, id_rd, id_shamt;
    logic [29:0] id_pc;
    logic [W-1:0] id_ra, id_rb, ex_result, mem_data;
    logic mem_regwr, flush;
    logic [4:0] mem_dst;
    logic stall_if, ex_valid, ex_regwr, ex_memrd, ex_memwr;
    logic [5:0] ex_op, ex_func;
    logic [4:0] ex_shamt, ex_dst;
    logic [29:0] ex_pc;
    logic [W-1:0] ex_a, ex_b;
    logic [15:0] ex_imm;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.W(W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_func(id_func), .id_pc(id_pc), .id_ra(id_ra), .id_rb(id_rb),
        .id_regwr(id_regwr), .id_regdst(id_regdst), .id_memrd(id_memrd), .id_memwr(id_memwr),
        .ex_result(ex_result), .mem_regwr(mem_regwr), .mem_dst(mem_dst), .mem_data(mem_data),
        .flush(flush), .stall_if(stall_if), .ex_valid(ex_valid), .ex_regwr(ex_regwr),
        .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_op(ex_op), .ex_func(ex_func),
        .ex_shamt(ex_shamt), .ex_dst(ex_dst), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm)
    );

    typedef enum logic [2:0] {K_R, K_ADDI, K_LW, K_SW, K_BR, K_LUI, K_JAL, K_JALR} kind_e;

    typedef struct packed {
        kind_e       kind;
        logic        valid, regwr, regdst, memrd, memwr;
        logic [5:0]  op, func;
        logic [4:0]  rs, rt, rd, shamt;
        logic [29:0] pc;
        logic [31:0] val;
    } instr_t;

    typedef struct packed {
        logic        valid, regwr, memrd;
        logic [4:0]  dst;
        logic [31:0] val, prev;
    } slot_t;

    typedef struct packed {
        logic        stall, valid, regwr, memrd, memwr;
        logic [5:0]  op, func;
        logic [4:0]  shamt, dst;
        logic [29:0] pc;
        logic [31:0] a, b;
        logic [15:0] imm;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [31:0] rf[32];       // register file as ID sees it (includes WB)
    logic [31:0] spec_rf[32];  // program-order value after every issued instruction
    slot_t ex_s, mem_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] dest_of(input instr_t i);
        if (!i.regwr) return 5'd0;
        case (i.kind)
            K_JAL, K_JALR: return 5'd31;
            K_R:           return i.rd;
            default:       return i.rt;
        endcase
    endfunction

    function automatic bit reads_rt(input instr_t i);
        return i.kind inside {K_R, K_JALR, K_SW, K_BR};
    endfunction

    function automatic bit hz_of(input instr_t i);
        return i.valid && ex_s.valid && ex_s.memrd && ex_s.dst != 5'd0 &&
               (ex_s.dst == i.rs || (reads_rt(i) && ex_s.dst == i.rt));
    endfunction

    // Latest value of r in program order; a load still in EX cannot supply it,
    // so a non-stalling reader sees the value from before that load.
    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (ex_s.valid && ex_s.memrd && ex_s.regwr && ex_s.dst == r) return ex_s.prev;
        return spec_rf[r];
    endfunction

    function automatic logic [4:0] rreg();
        int k = $urandom_range(0, 9);
        if (k < 8) return 5'(k);
        if (k == 8) return 5'd31;
        return 5'($urandom);
    endfunction

    function automatic logic [31:0] rval();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF;
        return $urandom;
    endfunction

    function automatic instr_t mk(input kind_e k, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] val);
        instr_t i;
        i.kind = k; i.valid = 1'b1; i.rs = rs; i.rt = rt; i.rd = rd; i.val = val;
        i.shamt = 5'($urandom); i.func = 6'($urandom); i.pc = 30'($urandom);
        i.regdst = 1'($urandom); i.regwr = 1'b1; i.memrd = 1'b0; i.memwr = 1'b0;
        case (k)
            K_R: begin
                i.op = 6'h00; i.regdst = 1'b1;
                case ($urandom_range(0, 3))
                    0: i.func = 6'h20;
                    1: i.func = 6'h22;
                    2: i.func = 6'h24;
                    default: i.func = 6'h2a;
                endcase
            end
            K_ADDI: begin i.op = 6'h08; i.regdst = 1'b0; end
            K_LW:   begin i.op = 6'h23; i.regdst = 1'b0; i.memrd = 1'b1; end
            K_SW:   begin i.op = 6'h2b; i.regdst = 1'b0; i.regwr = 1'b0; i.memwr = 1'b1; end
            K_BR:   begin i.op = 6'($urandom_range(4, 5)); i.regdst = 1'b0; i.regwr = 1'b0; end
            K_LUI:  i.op = 6'h0f;
            K_JAL:  i.op = 6'h03;
            default: begin
                i.op = 6'h00; i.rt = 5'd0; i.rd = 5'd31; i.shamt = 5'd0; i.func = 6'h09;
            end
        endcase
        return i;
    endfunction

    task automatic drive(input instr_t ins, input bit fl);
        ex_result = (ex_s.valid && ex_s.regwr && !ex_s.memrd) ? ex_s.val : $urandom;
        mem_regwr = mem_s.valid && mem_s.regwr;
        mem_dst   = mem_s.valid ? mem_s.dst : 5'($urandom);
        mem_data  = mem_s.valid ? mem_s.val : $urandom;
        id_valid = ins.valid; id_op = ins.op; id_func = ins.func; id_rs = ins.rs;
        id_rt = ins.rt; id_rd = ins.rd; id_shamt = ins.shamt; id_pc = ins.pc;
        id_regwr = ins.regwr; id_regdst = ins.regdst; id_memrd = ins.memrd; id_memwr = ins.memwr;
        id_ra = rf[ins.rs]; id_rb = rf[ins.rt]; flush = fl;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input instr_t ins, input bit fl, output bit stalled);
        exp_t e;
        slot_t ns;
        bit hz;
        logic [4:0] d;
        drive(ins, fl);
        d = dest_of(ins);
        hz = hz_of(ins);
        e = '0;
        e.stall = hz && !fl;
        if (!fl && !hz) begin
            e.valid = ins.valid; e.regwr = ins.regwr; e.memrd = ins.memrd; e.memwr = ins.memwr;
            e.op = ins.op; e.func = ins.func; e.shamt = ins.shamt; e.dst = d; e.pc = ins.pc;
            e.a = operand(ins.rs); e.b = operand(ins.rt);
            e.imm = {ins.rd, ins.shamt, ins.func};
        end
        #1 exp_q.push_back(e);
        @(posedge clk);
        if (mem_s.valid && mem_s.regwr && mem_s.dst != 5'd0) rf[mem_s.dst] = mem_s.val;
        mem_s = ex_s;
        ns = '0;
        if (!fl && !hz && ins.valid) begin
            ns.valid = 1'b1; ns.regwr = ins.regwr; ns.memrd = ins.memrd;
            ns.dst = d; ns.val = ins.val; ns.prev = spec_rf[d];
            if (ins.regwr && d != 5'd0) spec_rf[d] = ins.val;
        end
        ex_s = ns;
        stalled = hz && !fl;
        @(negedge clk);
    endtask

    // Re-presents a stalled instruction, as a held IF/ID register would.
    task automatic issue(input instr_t ins, input bit fl, input bit rand_fl);
        bit st;
        bit f = fl;
        for (int n = 0; n < 3; n++) begin
            step(ins, f, st);
            if (!st) break;
            if (rand_fl) f = ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall_if"}, stall_if, 0);
        check({tag, "_ex_valid"}, ex_valid, 0);
        check({tag, "_ex_regwr"}, ex_regwr, 0);
        check({tag, "_ex_memrd"}, ex_memrd, 0);
        check({tag, "_ex_memwr"}, ex_memwr, 0);
        check({tag, "_ex_op"}, ex_op, 0);
        check({tag, "_ex_func"}, ex_func, 0);
        check({tag, "_ex_shamt"}, ex_shamt, 0);
        check({tag, "_ex_dst"}, ex_dst, 0);
        check({tag, "_ex_pc"}, ex_pc, 0);
        check({tag, "_ex_a"}, ex_a, 0);
        check({tag, "_ex_b"}, ex_b, 0);
        check({tag, "_ex_imm"}, ex_imm, 0);
    endtask

    // Monitor: the item queued during a cycle describes stall_if in that cycle
    // and the EX register after the following rising edge.
    initial begin
        exp_t e;
        logic s;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                s = stall_if;
                @(posedge clk);
                #1;
                check("stall_if", s, e.stall);
                check("ex_valid", ex_valid, e.valid);
                check("ex_regwr", ex_regwr, e.regwr);
                check("ex_memrd", ex_memrd, e.memrd);
                check("ex_memwr", ex_memwr, e.memwr);
                check("ex_op", ex_op, e.op);
                check("ex_func", ex_func, e.func);
                check("ex_shamt", ex_shamt, e.shamt);
                check("ex_dst", ex_dst, e.dst);
                check("ex_pc", ex_pc, e.pc);
                check("ex_a", ex_a, e.a);
                check("ex_b", ex_b, e.b);
                check("ex_imm", ex_imm, e.imm);
            end
        end
    end

    initial begin
        instr_t ins;
        bit fl;
        reset = 1'b1;
        ex_s = '0; mem_s = '0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        rf[3] = 32'hDEAD;
        for (int i = 0; i < 32; i++) spec_rf[i] = rf[i];
        drive(mk(K_LW, 5'd1, 5'd5, 5'd0, 32'h1), 1'b0);
        #2 check_zero("reset_init");
        @(negedge clk);
        reset = 1'b0;

        // EX forwarding over a stale register-file value
        issue(mk(K_R, 5'd1, 5'd2, 5'd3, 32'h11), 1'b0, 1'b0);
        issue(mk(K_R, 5'd3, 5'd3, 5'd4, 32'h44), 1'b0, 1'b0);
        // EX beats MEM, then MEM alone, then register file at distance 3
        issue(mk(K_R, 5'd1, 5'd2, 5'd3, 32'h22), 1'b0, 1'b0);
        issue(mk(K_R, 5'd1, 5'd2, 5'd3, 32'h33), 1'b0, 1'b0);
        issue(mk(K_R, 5'd3, 5'd3, 5'd4, 32'h0), 1'b0, 1'b0);
        issue(mk(K_R, 5'd1, 5'd2, 5'd3, 32'h22), 1'b0, 1'b0);
        issue(mk(K_R, 5'd1, 5'd2, 5'd9, 32'h99), 1'b0, 1'b0);
        issue(mk(K_R, 5'd3, 5'd0, 5'd4, 32'h0), 1'b0, 1'b0);
        issue(mk(K_R, 5'd1, 5'd2, 5'd8, 32'h8), 1'b0, 1'b0);
        issue(mk(K_R, 5'd3, 5'd3, 5'd4, 32'h0), 1'b0, 1'b0);
        // load-use on rs, on a read rt, and a non-read rt
        issue(mk(K_LW, 5'd0, 5'd5, 5'd0, 32'h5A5A), 1'b0, 1'b0);
        issue(mk(K_R, 5'd5, 5'd0, 5'd6, 32'h6), 1'b0, 1'b0);
        issue(mk(K_LW, 5'd0, 5'd5, 5'd0, 32'h1234), 1'b0, 1'b0);
        issue(mk(K_SW, 5'd1, 5'd5, 5'd0, 32'h0), 1'b0, 1'b0);
        issue(mk(K_LW, 5'd0, 5'd5, 5'd0, 32'h4321), 1'b0, 1'b0);
        issue(mk(K_ADDI, 5'd1, 5'd5, 5'd2, 32'h77), 1'b0, 1'b0);
        // register zero is never forwarded and never causes a stall
        issue(mk(K_R, 5'd1, 5'd2, 5'd0, 32'hFFFF), 1'b0, 1'b0);
        issue(mk(K_LW, 5'd0, 5'd0, 5'd0, 32'hFFFF), 1'b0, 1'b0);
        issue(mk(K_R, 5'd0, 5'd0, 5'd7, 32'h7), 1'b0, 1'b0);
        // destination resolution
        issue(mk(K_JAL, 5'd1, 5'd2, 5'd3, 32'hA), 1'b0, 1'b0);
        issue(mk(K_JALR, 5'd1, 5'd0, 5'd31, 32'hB), 1'b0, 1'b0);
        issue(mk(K_LUI, 5'd0, 5'd7, 5'd3, 32'hC), 1'b0, 1'b0);
        // flush together with a load-use hazard
        issue(mk(K_LW, 5'd0, 5'd5, 5'd0, 32'hBEEF), 1'b0, 1'b0);
        issue(mk(K_R, 5'd5, 5'd5, 5'd6, 32'h6), 1'b1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            ins = mk(kind_e'($urandom_range(0, 7)), rreg(), rreg(), rreg(), rval());
            if (ins.kind == K_R) ins.regwr = ($urandom_range(0, 7) != 0);
            ins.valid = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 11) == 0);
            issue(ins, fl, 1'b1);
        end

        // reset arriving while the front end is stalled
        issue(mk(K_LW, 5'd0, 5'd5, 5'd0, 32'h5A5A), 1'b0, 1'b0);
        ins = mk(K_R, 5'd5, 5'd0, 5'd6, 32'h6);
        drive(ins, 1'b0);
        #3 check("stall_if_before_reset", stall_if, hz_of(ins));
        reset = 1'b1;
        #1 check_zero("reset_mid_stall");
        check("queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
